// File: rtl/lcd_seq_ctrl.sv
// LCD sequencing controller: one-shot panel init after reset, then serves
// queued draw requests as a position phase followed by a pixel-data phase.
// A per-phase watchdog traps hung engines in ERROR until software re-init.
module lcd_seq_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_begin,
  input  logic [ADDR_W-1:0] req_end,
  output logic              req_drop,
  input  logic              reinit,
  input  logic              ini_finish,
  input  logic              pos_finish,
  input  logic              run_finish,
  output logic              ini_en,
  output logic              pos_en,
  output logic              data_en,
  output logic              lcd_mode,
  output logic              sel,
  output logic [ADDR_W-1:0] run_addr_begin,
  output logic [ADDR_W-1:0] run_addr_end,
  output logic              frame_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_phase
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INI, S_WAIT_REQ, S_POS, S_RUN, S_ERROR
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_mem_b [DEPTH];
  logic [ADDR_W-1:0] r_mem_e [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [PW:0]       r_count, w_count_nxt;
  logic [TMO_W-1:0]  r_wd;
  logic              w_tmo, w_pop, w_push, w_flush, w_accept, w_bad;

  assign req_ready = (r_count != (PW+1)'(DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_bad     = req_begin > req_end;
  assign w_tmo     = (r_wd == TMO_W'(TMO_CYC - 1));

  // Next-state decode; a phase finish always takes priority over the watchdog.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:     w_next = S_INI;
      S_INI:      if (ini_finish) w_next = S_WAIT_REQ;
                  else if (w_tmo) w_next = S_ERROR;
      S_WAIT_REQ: if (reinit) w_next = S_IDLE;
                  else if (r_count != '0) begin
                    w_next = S_POS;
                    w_pop  = 1'b1;
                  end
      S_POS:      if (pos_finish) w_next = S_RUN;
                  else if (w_tmo) w_next = S_ERROR;
      S_RUN:      if (run_finish) w_next = S_WAIT_REQ;
                  else if (w_tmo) w_next = S_ERROR;
      S_ERROR:    if (reinit) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; the flush covers re-init and the whole ERROR residency.
  always_comb begin
    w_flush     = (w_next == S_ERROR) || (r_state == S_ERROR) ||
                  (r_state == S_WAIT_REQ && reinit);
    w_push      = w_accept && !w_bad && !w_flush;
    w_count_nxt = w_flush ? '0
                : r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  end

  // State register and watchdog (cleared on every state entry).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wd <= '0;
      else if (r_state == S_INI || r_state == S_POS || r_state == S_RUN)
        r_wd <= r_wd + 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
        if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_b[r_wr] <= req_begin;
      r_mem_e[r_wr] <= req_end;
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ini_en         <= 1'b0;
      pos_en         <= 1'b0;
      data_en        <= 1'b0;
      lcd_mode       <= 1'b0;
      sel            <= 1'b1;
      run_addr_begin <= '0;
      run_addr_end   <= '0;
      frame_done     <= 1'b0;
      req_drop       <= 1'b0;
      busy           <= 1'b1;  // IDLE is a busy state
      err            <= 1'b0;
      err_phase      <= 2'b00;
    end else begin
      ini_en     <= (w_next == S_INI);
      pos_en     <= (w_next == S_POS);
      data_en    <= (w_next == S_RUN);
      lcd_mode   <= (w_next == S_WAIT_REQ) || (w_next == S_POS) || (w_next == S_RUN);
      sel        <= (w_next != S_RUN);
      frame_done <= (r_state == S_RUN) && run_finish;
      req_drop   <= w_accept && w_bad;
      busy       <= !((w_next == S_WAIT_REQ) && (w_count_nxt == '0));
      err        <= (w_next == S_ERROR);
      if (w_next != S_ERROR)
        err_phase <= 2'b00;
      else if (r_state == S_INI)
        err_phase <= 2'b01;
      else if (r_state == S_POS)
        err_phase <= 2'b10;
      else if (r_state == S_RUN)
        err_phase <= 2'b11;
      if (w_pop) begin
        run_addr_begin <= r_mem_b[r_rd];
        run_addr_end   <= r_mem_e[r_rd];
      end
    end
  end

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
Parametrised LCD sequencing controller that owns the panel power-up and refresh flow. It runs the init engine once after reset, then serves queued draw requests. Each request gets a window/position phase followed by a pixel-data phase. It sits between the CPU-side register block (request queue) and the LCD init/position/data engines. It adds request buffering, a per-phase watchdog with error state, and software re-init over the previous single-request controller.

Parameters:
ADDR_W, 8, width of run_addr_begin/run_addr_end and request addresses
DEPTH, 4, request FIFO entries; power of 2, at least 2
TMO_W, 16, width of watchdog counter
TMO_CYC, 50000, cycles allowed in INI/POS/RUN before timeout; must be < 2^TMO_W

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  draw request offered
req_ready  out  1  FIFO can accept (= !full)
req_begin  in  ADDR_W  request start address
req_end  in  ADDR_W  request end address
req_drop  out  1  one-cycle pulse: offered request rejected (begin > end)
reinit  in  1  software re-init pulse
ini_finish  in  1  init engine done
pos_finish  in  1  position engine done
run_finish  in  1  data engine done
ini_en  out  1  init engine enable
pos_en  out  1  position engine enable
data_en  out  1  data engine enable
lcd_mode  out  1  0 = init/command mode, 1 = normal mode
sel  out  1  1 = command/position bus owner, 0 = data engine owner
run_addr_begin  out  ADDR_W  latched start address of active request
run_addr_end  out  ADDR_W  latched end address of active request
frame_done  out  1  one-cycle pulse on RUN completion
busy  out  1  high in any state except WAIT_REQ with FIFO empty
err  out  1  sticky timeout flag; cleared on leaving ERROR
err_phase  out  2  01 INI, 10 POS, 11 RUN, 00 none

Behaviour:
- Reset (rstn low, async): state IDLE. FIFO empty. All enables 0, lcd_mode 0, sel 1, addresses 0, pulses 0, err 0, err_phase 00, watchdog 0.
- All outputs are registered and valid in the same cycle the FSM occupies the state; they are decoded from next_state.
- States and transitions:
  - IDLE -> INI unconditionally; IDLE lasts 1 cycle.
  - INI: ini_en 1, lcd_mode 0, sel 1. On ini_finish -> WAIT_REQ.
  - WAIT_REQ: enables 0, lcd_mode 1, sel 1.
    - reinit -> IDLE (FIFO flushed).
    - Otherwise, FIFO non-empty -> POS, popping the head into run_addr_begin/end on that transition edge.
  - POS: pos_en 1, sel 1. On pos_finish -> RUN.
  - RUN: data_en 1, sel 0. On run_finish -> WAIT_REQ with frame_done pulsed for 1 cycle.
    - Back-to-back requests therefore spend exactly 1 cycle in WAIT_REQ.
  - ERROR: enables 0, lcd_mode 0, sel 1, err 1. Exit only on reinit -> IDLE; err and err_phase clear there.
- Watchdog:
  - Clears on every state entry.
  - Increments each cycle in INI/POS/RUN.
  - If it equals TMO_CYC-1 and the phase finish is low, go to ERROR, set err_phase, and flush the FIFO.
  - If finish and timeout occur in the same cycle, finish wins.
- reinit is ignored in INI/POS/RUN; a running phase is never aborted by software.
- FIFO behaviour:
  - Push when req_valid && req_ready && req_begin <= req_end.
  - If req_valid && req_ready && req_begin > req_end: no push, req_drop pulses next cycle.
  - req_ready depends only on the registered count, never combinationally on a same-cycle pop.
  - A push into an empty FIFO is visible next cycle, so the earliest POS entry is 2 cycles after acceptance.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Pushes are accepted in every state, including INI and ERROR. In ERROR, pushes are discarded by the flush until reinit.
- The finish inputs are sampled only in their own phase; stray pulses elsewhere are ignored.
- Reset mid-operation returns to IDLE immediately; no pending request survives.

Test Plan:
- Power-up: release rstn; ini_finish at cycle 10 -> ini_en high for cycles 2..10, then WAIT_REQ with lcd_mode 1, sel 1, busy 0.
- Single request: begin 0x10, end 0x3F after init -> POS 2 cycles later with run_addr 0x10/0x3F. pos_finish -> data_en 1, sel 0. run_finish -> frame_done pulse, back to WAIT_REQ.
- Queue full: push DEPTH+1 requests during INI -> req_ready low after DEPTH. Requests are served in FIFO order with 1-cycle WAIT_REQ gaps; request 5 is accepted once ready rises.
- Bad request: begin 0x20, end 0x1F -> req_drop pulse, count unchanged, no POS entry.
- Timeout: TMO_CYC=8, pos_finish withheld -> ERROR after 8 POS cycles, err 1, err_phase 10, FIFO flushed. reinit -> IDLE -> INI, err 0.
- Simultaneous events: run_finish and timeout in the same cycle -> WAIT_REQ, no error. Async rstn asserted during RUN -> all outputs return to reset values immediately.
